gpio_v2: RTL and testbench



---
 rtl/gpio_v2_if.sv | 22 ++
 rtl/gpio_v2.sv | 138 +++++++++++++
 tb/tb_gpio_v2.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_v2_if.sv
// gpio_v2 local bus interface.
// Master drives select/address/write strobes, slave returns registered read data.
interface gpio_v2_if #(
  parameter int XLEN   = 32,
  parameter int AWIDTH = 32
);
  logic              sel;
  logic [AWIDTH-1:0] addr;
  logic [2:0]        we;
  logic [XLEN-1:0]   wdata;
  logic [XLEN-1:0]   rdata;

  modport master (
    output sel, addr, we, wdata,
    input  rdata
  );

  modport slave (
    input  sel, addr, we, wdata,
    output rdata
  );
endinterface

// File: rtl/gpio_v2.sv
// gpio_v2: per-pin direction GPIO with synchroniser, prescaled glitch filter
// and sticky W1C edge interrupts collapsed onto one registered irq line.
module gpio_v2 #(
  parameter int NPIN      = 16,
  parameter int FLT_DEPTH = 3,
  parameter int XLEN      = 32,
  parameter int AWIDTH    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NPIN-1:0] gpio_pin_in,
  output logic [NPIN-1:0] gpio_pin_out,
  output logic [NPIN-1:0] gpio_pin_oe,
  output logic            irq,
  gpio_v2_if.slave        bus
);

  logic [NPIN-1:0]      s1, s2;
  logic [NPIN-1:0]      in_flt, in_prev, flt_nxt;
  logic [NPIN-1:0]      rise_en, fall_en, stat;
  logic [NPIN-1:0]      edge_set, stat_clr;
  logic [FLT_DEPTH-1:0] hist [NPIN];
  logic [7:0]           presc, cnt;
  logic                 flt_en, tick;
  logic [XLEN-1:0]      lane, wdm, rd;
  logic [NPIN-1:0]      wm, wd;
  logic [8:0]           cfg_new;
  logic [2:0]           ra;
  logic                 wr;
  logic                 unused_bits;

  assign unused_bits = ^{bus.addr, bus.wdata, lane, wdm};

  always_comb begin
    case (bus.we)
      3'b001:  lane = XLEN'(8'hff);
      3'b010:  lane = XLEN'(16'hffff);
      3'b100:  lane = '1;
      default: lane = '0;
    endcase
  end

  assign ra  = bus.addr[4:2];
  assign wr  = bus.sel && (lane != '0);
  assign wdm = bus.wdata & lane;
  assign wm  = lane[NPIN-1:0];
  assign wd  = wdm[NPIN-1:0];

  assign cfg_new = ({flt_en, presc} & ~lane[8:0]) | wdm[8:0];

  assign tick = (cnt == presc);

  // Filtered state only moves once the whole tick history agrees.
  always_comb begin
    flt_nxt = in_flt;
    for (int i = 0; i < NPIN; i++) begin
      if (!flt_en)
        flt_nxt[i] = s2[i];
      else if (&hist[i])
        flt_nxt[i] = 1'b1;
      else if (~|hist[i])
        flt_nxt[i] = 1'b0;
    end
  end

  assign edge_set = (in_flt & ~in_prev & rise_en)
                  | (~in_flt & in_prev & fall_en);

  assign stat_clr = (wr && ra == 3'd6) ? (wd & wm) : '0;

  always_comb begin
    rd = '0;
    case (ra)
      3'd0:    rd[NPIN-1:0] = in_flt;
      3'd1:    rd[NPIN-1:0] = gpio_pin_out;
      3'd2:    rd[NPIN-1:0] = gpio_pin_oe;
      3'd3:    rd[8:0]      = {flt_en, presc};
      3'd4:    rd[NPIN-1:0] = rise_en;
      3'd5:    rd[NPIN-1:0] = fall_en;
      3'd6:    rd[NPIN-1:0] = stat;
      default: rd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1           <= '0;
      s2           <= '0;
      in_flt       <= '0;
      in_prev      <= '0;
      rise_en      <= '0;
      fall_en      <= '0;
      stat         <= '0;
      presc        <= '0;
      flt_en       <= 1'b0;
      cnt          <= '0;
      gpio_pin_out <= '0;
      gpio_pin_oe  <= '0;
      irq          <= 1'b0;
      bus.rdata    <= '0;
      for (int i = 0; i < NPIN; i++)
        hist[i] <= '0;
    end else begin
      s1      <= gpio_pin_in;
      s2      <= s1;
      in_flt  <= flt_nxt;
      in_prev <= in_flt;
      // Set beats a same-cycle clear so no edge is lost.
      stat    <= (stat & ~stat_clr) | edge_set;
      irq     <= |stat;

      if (tick)
        for (int i = 0; i < NPIN; i++)
          hist[i] <= {hist[i][FLT_DEPTH-2:0], s2[i]};

      if (wr && ra == 3'd3)
        cnt <= '0;
      else if (tick)
        cnt <= '0;
      else
        cnt <= cnt + 8'd1;

      if (wr) begin
        case (ra)
          3'd1: gpio_pin_out <= (gpio_pin_out & ~wm) | wd;
          3'd2: gpio_pin_oe  <= (gpio_pin_oe & ~wm) | wd;
          3'd3: {flt_en, presc} <= cfg_new;
          3'd4: rise_en <= (rise_en & ~wm) | wd;
          3'd5: fall_en <= (fall_en & ~wm) | wd;
          default: ;
        endcase
      end

      bus.rdata <= bus.sel ? rd : '0;
    end
  end

endmodule

// File: tb/tb_gpio_v2.sv
// Directed self-checking bench for gpio_v2.
// Each task drives one scenario and checks inline at the negedge.
module tb_gpio_v2;

  localparam int NPIN = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NPIN-1:0] pins = '0;
  logic [NPIN-1:0] pout, poe;
  logic            irq;
  logic [31:0]     d;
  int              errs = 0;
  int              checks = 0;

  gpio_v2_if #(.XLEN(32), .AWIDTH(32)) bus ();

  gpio_v2 #(
    .NPIN(NPIN), .FLT_DEPTH(3), .XLEN(32), .AWIDTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .gpio_pin_in(pins),
    .gpio_pin_out(pout),
    .gpio_pin_oe(poe),
    .irq(irq),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge after the write edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] v,
                    input logic [2:0] w);
    bus.sel = 1'b1; bus.addr = a; bus.we = w; bus.wdata = v;
    @(negedge clk);
    bus.sel = 1'b0; bus.we = 3'b000;
  endtask

  task automatic rdreg(input logic [31:0] a, output logic [31:0] v);
    bus.sel = 1'b1; bus.addr = a; bus.we = 3'b000;
    @(negedge clk);
    v = bus.rdata;
    bus.sel = 1'b0;
  endtask

  task automatic test_reset;
    wr(32'h04, 32'hFFFF, 3'b100);
    wr(32'h10, 32'h0001, 3'b100);
    pins[0] = 1'b1;
    repeat (6) @(negedge clk);
    rdreg(32'h18, d);
    checks++;
    if (d !== 32'h1) begin
      errs++; $display("FAIL pre_rst_stat got %h want 1", d);
    end
    rst = 1'b1; pins = '0;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (pout !== '0 || poe !== '0 || irq !== 1'b0 || bus.rdata !== '0) begin
      errs++;
      $display("FAIL rst_outs got out=%h oe=%h irq=%b rd=%h want 0",
               pout, poe, irq, bus.rdata);
    end
    for (int i = 0; i < 8; i++) begin
      rdreg(32'(i * 4), d);
      checks++;
      if (d !== 32'h0) begin
        errs++; $display("FAIL rst_reg%0d got %h want 0", i, d);
      end
    end
  endtask

  task automatic test_basic_io;
    wr(32'h04, 32'hA5A5, 3'b100);
    checks++;
    if (pout !== 16'hA5A5) begin
      errs++; $display("FAIL out_word got %h want a5a5", pout);
    end
    wr(32'h08, 32'h00FF, 3'b100);
    checks++;
    if (poe !== 16'h00FF) begin
      errs++; $display("FAIL oe_word got %h want 00ff", poe);
    end
    wr(32'h07, 32'hFFFF_FF3C, 3'b001);
    checks++;
    if (pout !== 16'hA53C) begin
      errs++; $display("FAIL out_byte got %h want a53c", pout);
    end
    wr(32'h04, 32'h1234_5678, 3'b011);
    checks++;
    if (pout !== 16'hA53C) begin
      errs++; $display("FAIL illegal_we got %h want a53c", pout);
    end
    wr(32'h08, 32'hFFFF_BEEF, 3'b010);
    rdreg(32'h08, d);
    checks++;
    if (d !== 32'h0000_BEEF) begin
      errs++; $display("FAIL oe_half got %h want 0000beef", d);
    end
    wr(32'h1C, 32'hFFFF_FFFF, 3'b100);
    rdreg(32'h1C, d);
    checks++;
    if (d !== 32'h0) begin
      errs++; $display("FAIL reg1c got %h want 0", d);
    end
    wr(32'h00, 32'hFFFF, 3'b100);
    rdreg(32'h00, d);
    checks++;
    if (d !== 32'h0) begin
      errs++; $display("FAIL in_ro got %h want 0", d);
    end
    rdreg(32'h04, d);
    @(negedge clk);
    checks++;
    if (bus.rdata !== 32'h0) begin
      errs++; $display("FAIL idle_rdata got %h want 0", bus.rdata);
    end
    bus.sel = 1'b1; bus.addr = 32'h04; bus.we = 3'b100;
    bus.wdata = 32'hABCD_1111;
    @(negedge clk);
    bus.sel = 1'b0; bus.we = 3'b000;
    checks++;
    if (bus.rdata !== 32'h0000_A53C || pout !== 16'h1111) begin
      errs++;
      $display("FAIL rd_wr_same got rd=%h out=%h want 0000a53c 1111",
               bus.rdata, pout);
    end
  endtask

  task automatic test_unfiltered;
    pins[3] = 1'b1;
    bus.sel = 1'b1; bus.addr = 32'h00; bus.we = 3'b000;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.rdata[3] !== 1'b0) begin
      errs++; $display("FAIL unflt_early got %b want 0", bus.rdata[3]);
    end
    @(negedge clk);
    checks++;
    if (bus.rdata[3] !== 1'b1) begin
      errs++; $display("FAIL unflt_lat got %b want 1", bus.rdata[3]);
    end
    bus.sel = 1'b0;
    pins[3] = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_filter;
    wr(32'h0C, 32'h0000_0103, 3'b100);
    rdreg(32'h0C, d);
    checks++;
    if (d !== 32'h103) begin
      errs++; $display("FAIL cfg got %h want 103", d);
    end
    pins[0] = 1'b1;
    repeat (8) @(negedge clk);
    pins[0] = 1'b0;
    repeat (20) @(negedge clk);
    rdreg(32'h00, d);
    checks++;
    if (d[0] !== 1'b0) begin
      errs++; $display("FAIL flt_glitch got %b want 0", d[0]);
    end
    pins[0] = 1'b1;
    repeat (16) @(negedge clk);
    rdreg(32'h00, d);
    checks++;
    if (d[0] !== 1'b1) begin
      errs++; $display("FAIL flt_rise got %b want 1", d[0]);
    end
    pins[0] = 1'b0;
    repeat (4) @(negedge clk);
    rdreg(32'h00, d);
    checks++;
    if (d[0] !== 1'b1) begin
      errs++; $display("FAIL flt_hold got %b want 1", d[0]);
    end
    repeat (20) @(negedge clk);
    rdreg(32'h00, d);
    checks++;
    if (d[0] !== 1'b0) begin
      errs++; $display("FAIL flt_fall got %b want 0", d[0]);
    end
    wr(32'h0C, 32'h0, 3'b100);
  endtask

  task automatic test_irq;
    pins[0] = 1'b1;
    repeat (6) @(negedge clk);
    wr(32'h10, 32'h0010, 3'b100);
    wr(32'h14, 32'h0001, 3'b100);
    rdreg(32'h18, d);
    @(negedge clk);
    checks++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      errs++; $display("FAIL en_level got stat=%h irq=%b want 0 0", d, irq);
    end
    pins[4] = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errs++; $display("FAIL irq_early got %b want 0", irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      errs++; $display("FAIL irq_rise got %b want 1", irq);
    end
    rdreg(32'h18, d);
    checks++;
    if (d !== 32'h10) begin
      errs++; $display("FAIL stat_rise got %h want 10", d);
    end
    pins[0] = 1'b0;
    repeat (6) @(negedge clk);
    rdreg(32'h18, d);
    checks++;
    if (d !== 32'h11) begin
      errs++; $display("FAIL stat_fall got %h want 11", d);
    end
    wr(32'h18, 32'h0010, 3'b100);
    rdreg(32'h18, d);
    checks++;
    if (d !== 32'h01 || irq !== 1'b1) begin
      errs++; $display("FAIL w1c_4 got stat=%h irq=%b want 01 1", d, irq);
    end
    wr(32'h18, 32'h0001, 3'b100);
    checks++;
    if (irq !== 1'b1) begin
      errs++; $display("FAIL irq_lag got %b want 1", irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errs++; $display("FAIL irq_clr got %b want 0", irq);
    end
  endtask

  task automatic test_conflict;
    pins[4] = 1'b0;
    repeat (6) @(negedge clk);
    pins[4] = 1'b1;
    repeat (3) @(negedge clk);
    wr(32'h18, 32'h0010, 3'b100);
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      errs++; $display("FAIL conflict_irq got %b want 1", irq);
    end
    rdreg(32'h18, d);
    checks++;
    if (d !== 32'h10) begin
      errs++; $display("FAIL conflict_stat got %h want 10", d);
    end
  endtask

  task automatic test_lanes;
    wr(32'h10, 32'h1010, 3'b100);
    pins[12] = 1'b1;
    repeat (6) @(negedge clk);
    wr(32'h18, 32'hFFFF_FFFF, 3'b001);
    rdreg(32'h18, d);
    checks++;
    if (d !== 32'h1000) begin
      errs++; $display("FAIL stat_byte got %h want 1000", d);
    end
    wr(32'h18, 32'hFFFF_FFFF, 3'b010);
    repeat (2) @(negedge clk);
    rdreg(32'h18, d);
    checks++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      errs++; $display("FAIL stat_half got stat=%h irq=%b want 0 0", d, irq);
    end
  endtask

  initial begin
    bus.sel = 1'b0; bus.addr = '0; bus.we = 3'b000; bus.wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_basic_io();
    test_unfiltered();
    test_filter();
    test_irq();
    test_conflict();
    test_lanes();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
